mem_ss_cal_monitor: RTL and testbench
=====================================

MEM_SS_CAL_MONITOR -- requirements
Module: mem_ss_cal_monitor

Interface
REQ-001 Parameter DDR_CHANNEL, default 4, number of EMIF channels reported by the memory subsystem CSR block.
REQ-002 Parameter EXP_FEAT_ID, default 12'h009, feature ID expected in the EMIF DFH.
REQ-003 Parameter POLL_GAP, default 1024, idle cycles between consecutive EMIF_STATUS reads.
REQ-004 Parameter MAX_POLLS, default 1000, number of EMIF_STATUS reads before timeout.
REQ-005 Port clk, input, 1, sole clock.
REQ-006 Port rst_n, input, 1, reset: asynchronous, active-low.
REQ-007 Port start, input, 1, single-cycle request to run one check sequence.
REQ-008 Port arvalid, output, 1, AXI4-lite read-address valid.
REQ-009 Port araddr, output, 11, AXI4-lite byte address.
REQ-010 Port arready, input, 1, AXI4-lite read-address ready.
REQ-011 Port rvalid, input, 1, AXI4-lite read-data valid.
REQ-012 Port rdata, input, 64, AXI4-lite read data.
REQ-013 Port rresp, input, 2, AXI4-lite read response.
REQ-014 Port rready, output, 1, AXI4-lite read-data ready.
REQ-015 Port busy, output, 1, high while a sequence is in progress.
REQ-016 Port done, output, 1, sticky completion flag; cleared by the next accepted start.
REQ-017 Port status, output, 3, completion code: 0 pass, 1 dfh_err, 2 cal_fail, 3 timeout, 4 bus_err.
REQ-018 Port cal_success_q, output, DDR_CHANNEL, last EMIF_STATUS[DDR_CHANNEL-1:0] captured.
REQ-019 Port cal_fail_q, output, DDR_CHANNEL, last EMIF_STATUS[2*DDR_CHANNEL-1:DDR_CHANNEL] captured.
REQ-020 Port chan_mask, output, DDR_CHANNEL, EMIF_CAPABILITY[DDR_CHANNEL-1:0] captured.

Function
REQ-021 The block SHALL be a read-only AXI4-lite initiator with at most one outstanding read.
REQ-022 The FSM SHALL have states IDLE, AR_DFH, R_DFH, AR_CAP, R_CAP, AR_STAT, R_STAT, GAP and DONE.
REQ-023 In IDLE or DONE, start SHALL go to AR_DFH, clear done, clear poll count and drive busy=1 from the next cycle.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 AR_* states SHALL hold arvalid=1 with stable araddr until arready=1. Addresses: DFH 11'h000, CAP 11'h010, STAT 11'h008.
REQ-026 A handshake (arvalid&arready) SHALL move the FSM to the matching R_* state in the next cycle, with arvalid=0.
REQ-027 R_* states SHALL hold rready=1 and consume data only on rvalid&rready. rready SHALL be 0 in all other states.
REQ-028 If rresp!=2'b00 on any beat, the FSM SHALL go to DONE with status=4.
REQ-029 R_DFH SHALL check rdata[63:60]==4'h3 and rdata[11:0]==EXP_FEAT_ID; on mismatch go to DONE with status=1, else go to AR_CAP.
REQ-030 R_CAP SHALL load chan_mask and go to AR_STAT. If chan_mask==0, it SHALL go to DONE with status=1.
REQ-031 R_STAT SHALL load cal_success_q and cal_fail_q and increment the poll counter.
REQ-032 In R_STAT, if (fail & chan_mask)!=0, go to DONE with status=2; this has priority over pass.
REQ-033 Else, if (success & chan_mask)==chan_mask, go to DONE with status=0.
REQ-034 Else, if the poll count equals MAX_POLLS, go to DONE with status=3.
REQ-035 Else go to GAP.
REQ-036 GAP SHALL count POLL_GAP cycles, then go to AR_STAT.
REQ-037 The poll counter SHALL be $clog2(MAX_POLLS+1) bits and SHALL NOT wrap.
REQ-038 On entering DONE: done=1 and busy=0; status and captured values SHALL hold until the next start.
REQ-039 Bits of rdata outside the fields used SHALL be ignored.

Reset
REQ-040 While rst_n=0, all outputs SHALL be asynchronously reset to 0 and the FSM to IDLE.
REQ-041 Reset asserted mid-transaction SHALL abandon the transaction; no response is expected after reset release.
REQ-042 After reset release, no read SHALL be issued until start.

Verification
REQ-043 Pass: DFH 64'h3000_0010_0000_1009, CAP 4'hF, first STAT 8'h0F -> done=1, status=0, exactly 3 reads.
REQ-044 Polling: STAT returns 8'h03 for 5 reads, then 8'h0F -> 6 STAT reads with >=POLL_GAP idle cycles between reads, status=0.
REQ-045 Cal fail: CAP 4'h3, STAT 8'h13 -> status=2. A second run with CAP 4'h3, STAT 8'h43 (fail on a masked channel) -> status=0.
REQ-046 DFH error: rdata[11:0]=12'h00A -> status=1 after 1 read. SLVERR on the CAP read -> status=4.
REQ-047 Timeout: MAX_POLLS=4, STAT always 8'h00 -> status=3 after exactly 4 STAT reads.
REQ-048 Stall and reset: arready held low 50 cycles -> araddr stable; rst_n pulsed during R_STAT -> all outputs 0, start ignored while busy.

Source files
------------

// File: rtl/mem_ss_cal_monitor.sv
// Memory-subsystem calibration monitor: reads the EMIF DFH and capability registers
// over AXI4-lite, then polls EMIF_STATUS until every enabled channel calibrates or fails.
module mem_ss_cal_monitor #(
  parameter int          DDR_CHANNEL = 4,
  parameter logic [11:0] EXP_FEAT_ID = 12'h009,
  parameter int          POLL_GAP    = 1024,
  parameter int          MAX_POLLS   = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   arvalid,
  output logic [10:0]            araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [63:0]            rdata,
  input  logic [1:0]             rresp,
  output logic                   rready,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             status,
  output logic [DDR_CHANNEL-1:0] cal_success_q,
  output logic [DDR_CHANNEL-1:0] cal_fail_q,
  output logic [DDR_CHANNEL-1:0] chan_mask
);

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);
  localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);

  localparam logic [2:0] CODE_PASS    = 3'd0;
  localparam logic [2:0] CODE_DFH_ERR = 3'd1;
  localparam logic [2:0] CODE_CAL_ERR = 3'd2;
  localparam logic [2:0] CODE_TIMEOUT = 3'd3;
  localparam logic [2:0] CODE_BUS_ERR = 3'd4;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    AR_DFH  = 4'd1,
    R_DFH   = 4'd2,
    AR_CAP  = 4'd3,
    R_CAP   = 4'd4,
    AR_STAT = 4'd5,
    R_STAT  = 4'd6,
    GAP     = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [PW-1:0]          poll_cnt_r;
  logic [PW-1:0]          poll_next_s;
  logic [GW-1:0]          gap_cnt_r;
  logic                   start_ok_s;
  logic                   fin_s;
  logic [2:0]             fin_code_s;
  logic                   ld_mask_s;
  logic                   ld_stat_s;
  logic                   beat_s;
  logic                   resp_ok_s;
  logic                   dfh_ok_s;
  logic [DDR_CHANNEL-1:0] succ_s;
  logic [DDR_CHANNEL-1:0] fail_s;
  logic                   unused_rdata_s;

  function automatic logic is_ar(input state_t s);
    case (s)
      AR_DFH, AR_CAP, AR_STAT: is_ar = 1'b1;
      default:                 is_ar = 1'b0;
    endcase
  endfunction

  function automatic logic is_r(input state_t s);
    case (s)
      R_DFH, R_CAP, R_STAT: is_r = 1'b1;
      default:              is_r = 1'b0;
    endcase
  endfunction

  function automatic logic [10:0] addr_of(input state_t s);
    case (s)
      AR_DFH:  addr_of = 11'h000;
      AR_CAP:  addr_of = 11'h010;
      AR_STAT: addr_of = 11'h008;
      default: addr_of = 11'h000;
    endcase
  endfunction

  assign beat_s         = rvalid & rready;
  assign resp_ok_s      = (rresp == 2'b00);
  assign dfh_ok_s       = (rdata[63:60] == 4'h3) && (rdata[11:0] == EXP_FEAT_ID);
  assign succ_s         = rdata[DDR_CHANNEL-1:0];
  assign fail_s         = rdata[2*DDR_CHANNEL-1:DDR_CHANNEL];
  assign unused_rdata_s = ^rdata;
  // Saturating so the counter never wraps even if the limit check were bypassed.
  assign poll_next_s    = (poll_cnt_r == POLL_LIMIT) ? poll_cnt_r : poll_cnt_r + PW'(1);

  // Next-state and completion decode
  always_comb begin
    next_state_s = state_r;
    start_ok_s   = 1'b0;
    fin_s        = 1'b0;
    fin_code_s   = CODE_PASS;
    ld_mask_s    = 1'b0;
    ld_stat_s    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          next_state_s = AR_DFH;
          start_ok_s   = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      AR_DFH, AR_CAP, AR_STAT: begin
        if (arvalid && arready) begin
          next_state_s = (state_r == AR_DFH) ? R_DFH : ((state_r == AR_CAP) ? R_CAP : R_STAT);
        end else begin
          next_state_s = state_r;
        end
      end
      R_DFH: begin
        if (!beat_s) begin
          next_state_s = R_DFH;
        end else if (!resp_ok_s) begin
          next_state_s = DONE; fin_s = 1'b1; fin_code_s = CODE_BUS_ERR;
        end else if (!dfh_ok_s) begin
          next_state_s = DONE; fin_s = 1'b1; fin_code_s = CODE_DFH_ERR;
        end else begin
          next_state_s = AR_CAP;
        end
      end
      R_CAP: begin
        if (!beat_s) begin
          next_state_s = R_CAP;
        end else if (!resp_ok_s) begin
          next_state_s = DONE; fin_s = 1'b1; fin_code_s = CODE_BUS_ERR;
        end else if (succ_s == '0) begin
          ld_mask_s = 1'b1;
          next_state_s = DONE; fin_s = 1'b1; fin_code_s = CODE_DFH_ERR;
        end else begin
          ld_mask_s = 1'b1;
          next_state_s = AR_STAT;
        end
      end
      R_STAT: begin
        if (!beat_s) begin
          next_state_s = R_STAT;
        end else if (!resp_ok_s) begin
          next_state_s = DONE; fin_s = 1'b1; fin_code_s = CODE_BUS_ERR;
        end else begin
          ld_stat_s = 1'b1;
          if ((fail_s & chan_mask) != '0) begin
            next_state_s = DONE; fin_s = 1'b1; fin_code_s = CODE_CAL_ERR;
          end else if ((succ_s & chan_mask) == chan_mask) begin
            next_state_s = DONE; fin_s = 1'b1; fin_code_s = CODE_PASS;
          end else if (poll_next_s == POLL_LIMIT) begin
            next_state_s = DONE; fin_s = 1'b1; fin_code_s = CODE_TIMEOUT;
          end else begin
            next_state_s = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          next_state_s = AR_STAT;
        end else begin
          next_state_s = GAP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register with poll and gap counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      poll_cnt_r <= '0;
      gap_cnt_r  <= '0;
    end else begin
      state_r <= next_state_s;
      if (start_ok_s) begin
        poll_cnt_r <= '0;
      end else if (ld_stat_s) begin
        poll_cnt_r <= poll_next_s;
      end
      if ((state_r == GAP) && (next_state_s == GAP)) begin
        gap_cnt_r <= gap_cnt_r + GW'(1);
      end else begin
        gap_cnt_r <= '0;
      end
    end
  end

  // Registered bus controls, completion flags and captured register fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid       <= 1'b0;
      araddr        <= 11'h000;
      rready        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      status        <= 3'd0;
      cal_success_q <= '0;
      cal_fail_q    <= '0;
      chan_mask     <= '0;
    end else begin
      arvalid <= is_ar(next_state_s);
      araddr  <= addr_of(next_state_s);
      rready  <= is_r(next_state_s);
      busy    <= (next_state_s != IDLE) && (next_state_s != DONE);
      if (start_ok_s) begin
        done   <= 1'b0;
        status <= CODE_PASS;
      end else if (fin_s) begin
        done   <= 1'b1;
        status <= fin_code_s;
      end
      if (ld_mask_s) begin
        chan_mask <= succ_s;
      end
      if (ld_stat_s) begin
        cal_success_q <= succ_s;
        cal_fail_q    <= fail_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_ss_cal_monitor.sv
// Bench for mem_ss_cal_monitor: an AXI4-lite read responder with random latency and
// filler bits, checked against a register-level model of the check sequence.
module tb_mem_ss_cal_monitor;
  localparam int NCH = 4;
  localparam int GAPC = 16;
  localparam int MPA = 8;
  localparam int MPB = 4;

  logic clk = 1'b0;
  logic rst_n, start_a, start_b, sel;
  logic arready, rvalid;
  logic [63:0] rdata;
  logic [1:0] rresp;

  logic a_arvalid, a_rready, a_busy, a_done, b_arvalid, b_rready, b_busy, b_done;
  logic [10:0] a_araddr, b_araddr;
  logic [2:0] a_status, b_status;
  logic [NCH-1:0] a_suc, a_fl, a_msk, b_suc, b_fl, b_msk;

  logic arvalid_m, rready_m, busy_m, done_m;
  logic [10:0] araddr_m;
  logic [2:0] status_m;
  logic [NCH-1:0] suc_m, fl_m, msk_m;
  assign arvalid_m = sel ? b_arvalid : a_arvalid;
  assign rready_m  = sel ? b_rready  : a_rready;
  assign busy_m    = sel ? b_busy    : a_busy;
  assign done_m    = sel ? b_done    : a_done;
  assign araddr_m  = sel ? b_araddr  : a_araddr;
  assign status_m  = sel ? b_status  : a_status;
  assign suc_m     = sel ? b_suc     : a_suc;
  assign fl_m      = sel ? b_fl      : a_fl;
  assign msk_m     = sel ? b_msk     : a_msk;

  always #5 clk = ~clk;

  mem_ss_cal_monitor #(.DDR_CHANNEL(NCH), .EXP_FEAT_ID(12'h009), .POLL_GAP(GAPC), .MAX_POLLS(MPA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .arvalid(a_arvalid), .araddr(a_araddr),
    .arready(arready), .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(a_rready),
    .busy(a_busy), .done(a_done), .status(a_status), .cal_success_q(a_suc),
    .cal_fail_q(a_fl), .chan_mask(a_msk));

  mem_ss_cal_monitor #(.DDR_CHANNEL(NCH), .EXP_FEAT_ID(12'h009), .POLL_GAP(GAPC), .MAX_POLLS(MPB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .arvalid(b_arvalid), .araddr(b_araddr),
    .arready(arready), .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(b_rready),
    .busy(b_busy), .done(b_done), .status(b_status), .cal_success_q(b_suc),
    .cal_fail_q(b_fl), .chan_mask(b_msk));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Register contents served by the responder
  logic [63:0] dfh_w, cap_w, stat_def;
  logic [63:0] stat_arr[$];
  int err_at, err_idx, stall_n;
  bit hold_stat;

  // Responder bookkeeping
  int n_reads, n_stat_ar, stat_rd_idx, min_gap, last_stat_r, addr_unstable;
  logic [10:0] addr_log[$];
  bit have_data;
  int rdly;
  logic [63:0] nx_data;
  logic [1:0] nx_resp;
  logic [10:0] cur_addr, p_araddr;
  logic p_arvalid, p_arready, p_rvalid, p_rready;

  // Inputs change only on negedges and DUT outputs only on posedges, so values seen
  // at one negedge are exactly those present at the following posedge.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = 64'h0; rresp = 2'b00; have_data = 1'b0;
    p_arvalid = 1'b0; p_arready = 1'b0; p_rvalid = 1'b0; p_rready = 1'b0;
    p_araddr = 11'h000; cur_addr = 11'h000; rdly = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        arready = 1'b0; rvalid = 1'b0; have_data = 1'b0;
        p_arvalid = 1'b0; p_arready = 1'b0; p_rvalid = 1'b0; p_rready = 1'b0;
      end else begin
        if (p_rvalid && p_rready) begin
          rvalid = 1'b0; rresp = 2'b00; rdata = {$urandom, $urandom};
          if (cur_addr == 11'h008) last_stat_r = cyc;
        end
        if (p_arvalid && p_arready) begin
          arready = 1'b0; n_reads++; cur_addr = p_araddr; addr_log.push_back(p_araddr);
          nx_resp = 2'b00;
          case (p_araddr)
            11'h000: begin
              nx_data = dfh_w;
              if (err_at == 1) nx_resp = 2'($urandom_range(1, 3));
            end
            11'h010: begin
              nx_data = cap_w;
              if (err_at == 2) nx_resp = 2'($urandom_range(1, 3));
            end
            11'h008: begin
              nx_data = (stat_arr.size() > 0) ? stat_arr.pop_front() : stat_def;
              if (err_at == 3 && stat_rd_idx == err_idx) nx_resp = 2'($urandom_range(1, 3));
              stat_rd_idx++; n_stat_ar++;
              if (last_stat_r >= 0 && (cyc - last_stat_r) < min_gap) min_gap = cyc - last_stat_r;
            end
            default: nx_data = {$urandom, $urandom};
          endcase
          rdly = $urandom_range(0, 2); have_data = 1'b1;
        end else if (arvalid_m && p_arvalid && (araddr_m != p_araddr)) begin
          addr_unstable++;
        end
        if (have_data && !rvalid && !(hold_stat && cur_addr == 11'h008)) begin
          if (rdly == 0) begin
            rvalid = 1'b1; rdata = nx_data; rresp = nx_resp; have_data = 1'b0;
          end else begin
            rdly--;
          end
        end
        if (arvalid_m && !arready && !have_data && !rvalid && !(p_arvalid && p_arready)) begin
          if (stall_n > 0) stall_n--;
          else arready = 1'b1;
        end
        p_arvalid = arvalid_m; p_arready = arready; p_rvalid = rvalid;
        p_rready = rready_m; p_araddr = araddr_m;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-level outcome of one check sequence for the current register contents.
  function automatic void model(input int mp, output logic [2:0] st, output int nrd,
                                output logic [3:0] msk, output logic [3:0] suc,
                                output logic [3:0] fl, output bit mld, output bit sld);
    logic [63:0] s;
    st = 3'd0; nrd = 1; msk = 4'h0; suc = 4'h0; fl = 4'h0; mld = 1'b0; sld = 1'b0;
    if (err_at == 1) begin st = 3'd4; return; end
    if (dfh_w[63:60] != 4'h3 || dfh_w[11:0] != 12'h009) begin st = 3'd1; return; end
    nrd = 2;
    if (err_at == 2) begin st = 3'd4; return; end
    msk = cap_w[3:0]; mld = 1'b1;
    if (msk == 4'h0) begin st = 3'd1; return; end
    for (int k = 0; k < mp; k++) begin
      nrd++;
      if (err_at == 3 && k == err_idx) begin st = 3'd4; sld = 1'b0; return; end
      s = (k < stat_arr.size()) ? stat_arr[k] : stat_def;
      suc = s[3:0]; fl = s[7:4]; sld = 1'b1;
      if ((fl & msk) != 4'h0) begin st = 3'd2; return; end
      if ((suc & msk) == msk) begin st = 3'd0; return; end
    end
    st = 3'd3;
  endfunction

  task automatic run(input bit s, input int mp, input string tag, input int poke_at);
    logic [2:0] e_st;
    int e_n, ord_err;
    logic [3:0] e_m, e_s, e_f;
    bit mld, sld, seen;
    logic [10:0] e_addr;
    model(mp, e_st, e_n, e_m, e_s, e_f, mld, sld);
    n_reads = 0; n_stat_ar = 0; stat_rd_idx = 0; min_gap = 1000000; last_stat_r = -1;
    addr_unstable = 0; addr_log.delete();
    sel = s;
    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk({tag, "_busy"}, 64'(busy_m), 64'd1);
    chk({tag, "_done_clr"}, 64'(done_m), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (i == poke_at) begin
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (done_m) seen = 1'b1;
    end
    start_a = 1'b0; start_b = 1'b0;
    chk({tag, "_completes"}, 64'(seen), 64'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_status"}, 64'(status_m), 64'(e_st));
    chk({tag, "_busy_end"}, 64'(busy_m), 64'd0);
    chk({tag, "_reads"}, 64'(n_reads), 64'(e_n));
    chk({tag, "_idle_bus"}, 64'({arvalid_m, rready_m}), 64'd0);
    ord_err = 0;
    foreach (addr_log[i]) begin
      e_addr = (i == 0) ? 11'h000 : ((i == 1) ? 11'h010 : 11'h008);
      if (addr_log[i] != e_addr) ord_err++;
    end
    chk({tag, "_addr_order"}, 64'(ord_err), 64'd0);
    if (mld) chk({tag, "_chan_mask"}, 64'(msk_m), 64'(e_m));
    if (sld) chk({tag, "_cal_q"}, 64'({suc_m, fl_m}), 64'({e_s, e_f}));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, 64'(a_arvalid), 64'd0);
    chk({tag, "_araddr"}, 64'(a_araddr), 64'd0);
    chk({tag, "_rready"}, 64'(a_rready), 64'd0);
    chk({tag, "_busy"}, 64'(a_busy), 64'd0);
    chk({tag, "_done"}, 64'(a_done), 64'd0);
    chk({tag, "_status"}, 64'(a_status), 64'd0);
    chk({tag, "_cal_q"}, 64'({a_suc, a_fl}), 64'd0);
    chk({tag, "_chan_mask"}, 64'(a_msk), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    dfh_w = 64'h3000_0010_0000_1009; cap_w = 64'h0000_0000_0000_000F; stat_def = 64'h0;
    err_at = 0; err_idx = 0; stall_n = 0; hold_stat = 1'b0;
    n_reads = 0; n_stat_ar = 0; stat_rd_idx = 0; min_gap = 1000000; last_stat_r = -1;
    addr_unstable = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_read_before_start", 64'(n_reads), 64'd0);

    stat_arr = '{64'h0F};
    run(1'b0, MPA, "pass", -1);
    chk("pass_three_reads", 64'(n_reads), 64'd3);

    stat_arr = '{64'h03, 64'h03, 64'h03, 64'h03, 64'h03, 64'h0F};
    run(1'b0, MPA, "poll", 40);
    chk("poll_stat_reads", 64'(n_stat_ar), 64'd6);
    chk("poll_gap", 64'(min_gap > GAPC), 64'd1);

    cap_w = 64'h3; stat_arr = '{64'h13};
    run(1'b0, MPA, "calfail", -1);
    chk("calfail_code", 64'(status_m), 64'd2);
    stat_arr = '{64'h43};
    run(1'b0, MPA, "masked_fail", -1);
    chk("masked_fail_code", 64'(status_m), 64'd0);

    cap_w = 64'hF; dfh_w = 64'h3000_0010_0000_100A;
    run(1'b0, MPA, "dfh_err", -1);
    chk("dfh_err_code", 64'(status_m), 64'd1);
    dfh_w = 64'h3000_0010_0000_1009; err_at = 2;
    run(1'b0, MPA, "slverr_cap", -1);
    chk("slverr_cap_code", 64'(status_m), 64'd4);
    err_at = 0;

    stat_arr.delete(); stat_def = 64'h00;
    run(1'b1, MPB, "timeout", -1);
    chk("timeout_code", 64'(status_m), 64'd3);
    chk("timeout_stat_reads", 64'(n_stat_ar), 64'd4);

    stall_n = 50; stat_arr = '{64'h0F};
    run(1'b0, MPA, "stall", -1);
    chk("stall_addr_stable", 64'(addr_unstable), 64'd0);
    chk("stall_consumed", 64'(stall_n), 64'd0);

    for (int r = 0; r < 12; r++) begin
      dfh_w = {$urandom, $urandom}; dfh_w[63:60] = 4'h3; dfh_w[11:0] = 12'h009;
      if ($urandom_range(0, 7) == 0) dfh_w[11:0] = 12'h009 ^ 12'($urandom_range(1, 4095));
      if ($urandom_range(0, 7) == 0) dfh_w[63:60] = 4'h3 ^ 4'($urandom_range(1, 15));
      cap_w = {$urandom, $urandom};
      stat_arr.delete();
      for (int k = 0; k < MPA; k++) begin
        nx_data = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) nx_data[7:4] = 4'h0;
        stat_arr.push_back(nx_data);
      end
      err_idx = $urandom_range(0, 3);
      err_at = $urandom_range(0, 9);
      if (err_at > 3) err_at = 0;
      run(1'b0, MPA, $sformatf("rnd%0d", r), -1);
    end
    err_at = 0;

    // Abandon a STAT read mid-flight with reset and confirm nothing resumes.
    dfh_w = 64'h3000_0010_0000_1009; cap_w = 64'hF; stat_arr.delete(); stat_def = 64'h03;
    hold_stat = 1'b1; sel = 1'b0; n_stat_ar = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 500 && n_stat_ar == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("rstat_rready", 64'(a_rready), 64'd1);
    chk("rstat_busy", 64'(a_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1; hold_stat = 1'b0; n_reads = 0;
    repeat (30) @(negedge clk);
    chk("post_reset_no_reads", 64'(n_reads), 64'd0);
    chk("post_reset_idle", 64'({a_busy, a_done, a_arvalid}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
